// File: rtl/response_collector.sv
// -----------------------------------------------------------------------------
// response_collector
//
// Gathers one response per targeted egress port after a parallel issue,
// tracks which ports are still outstanding, merges their error flags and
// presents a single completion record to the controlling engine.
//
// Optional feature macro: TSWITCH_COLLECTOR_TIMEOUT_EN
//   defined     -> a WAIT-cycle timer forces a timeout completion once it
//                  reaches TIMEOUT_CYCLES-1 with ports still outstanding.
//   not defined -> no timer; WAIT lasts until every expected port answers
//                  or abort is raised; done_timeout is tied to 0.
// -----------------------------------------------------------------------------
module response_collector #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,

  // Control from the issuing engine
  input  logic                 arm,
  input  logic [NUM_PORTS-1:0] expect_mask,
  input  logic                 abort,

  // Per-port response channels
  input  logic [NUM_PORTS-1:0] resp_valid,
  input  logic [NUM_PORTS-1:0] resp_err,
  output logic [NUM_PORTS-1:0] resp_ready,

  // Completion record
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 done_err,
  output logic [NUM_PORTS-1:0] done_err_mask,
  output logic                 done_timeout,

  // Status
  output logic [NUM_PORTS-1:0] pending,
  output logic                 busy
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q,    state_d;
  logic [NUM_PORTS-1:0] pending_q,  pending_d;
  logic [NUM_PORTS-1:0] err_mask_q, err_mask_d;
  logic                 timeout_q,  timeout_d;

  // Handshake bookkeeping for the current WAIT cycle
  logic [NUM_PORTS-1:0] accepted;
  logic [NUM_PORTS-1:0] remaining;
  logic                 timer_expired;

`ifdef TSWITCH_COLLECTOR_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // WAIT-cycle timer
  // ---------------------------------------------------------------------------
  localparam int            TIMER_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;

  // Count WAIT cycles, saturating at the limit; cleared on arm and abort.
  always_comb begin
    timer_d = timer_q;
    if (abort) begin
      timer_d = '0;
    end else if (state_q == ST_IDLE && arm) begin
      timer_d = '0;
    end else if (state_q == ST_WAIT && timer_q != TIMER_MAX) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign timer_expired = (timer_q == TIMER_MAX);
`else
  // Without the timeout path the limit never fires and the size parameter
  // is only kept for a uniform instantiation interface.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timer_expired      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Per-port handshake
  // ---------------------------------------------------------------------------
  // Only outstanding ports are ready, only in WAIT, and never while abort is
  // raised, so a response racing an abort is left untouched at the port.
  assign resp_ready = (state_q == ST_WAIT && !abort) ? pending_q : '0;
  assign accepted   = resp_valid & resp_ready;
  assign remaining  = pending_q & ~accepted;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Sequence IDLE -> WAIT -> DONE -> IDLE, with abort overriding everything.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave it unassigned and infer a latch.
    state_d    = state_q;
    pending_d  = pending_q;
    err_mask_d = err_mask_q;
    timeout_d  = timeout_q;

    if (abort) begin
      state_d    = ST_IDLE;
      pending_d  = '0;
      err_mask_d = '0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            pending_d  = expect_mask;
            err_mask_d = '0;
            timeout_d  = 1'b0;
            state_d    = (expect_mask == '0) ? ST_DONE : ST_WAIT;
          end
        end

        ST_WAIT: begin
          pending_d  = remaining;
          err_mask_d = (err_mask_q & ~accepted) | (resp_err & accepted);
          if (remaining == '0) begin
            // Completion wins over a coincident timer expiry.
            state_d = ST_DONE;
          end else if (timer_expired) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end

        ST_DONE: begin
          if (done_ready) state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // Capture next state; reset clears the whole record asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      err_mask_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      err_mask_q <= err_mask_d;
      timeout_q  <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign done_valid    = (state_q == ST_DONE);
  assign done_err_mask = err_mask_q;
  assign done_timeout  = timeout_q;
  assign done_err      = (|err_mask_q) | timeout_q;
  assign pending       = pending_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_response_collector.sv
// -----------------------------------------------------------------------------
// tb_response_collector
//
// Directed bench for response_collector (NUM_PORTS=4, TIMEOUT_CYCLES=8).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_response_collector;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm;
  logic [NP-1:0] expect_mask;
  logic          abort;
  logic [NP-1:0] resp_valid;
  logic [NP-1:0] resp_err;
  logic [NP-1:0] resp_ready;
  logic          done_valid;
  logic          done_ready;
  logic          done_err;
  logic [NP-1:0] done_err_mask;
  logic          done_timeout;
  logic [NP-1:0] pending;
  logic          busy;

  int tests = 0;
  int fails = 0;

  response_collector #(
    .NUM_PORTS      (NP),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arm           (arm),
    .expect_mask   (expect_mask),
    .abort         (abort),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_ready    (resp_ready),
    .done_valid    (done_valid),
    .done_ready    (done_ready),
    .done_err      (done_err),
    .done_err_mask (done_err_mask),
    .done_timeout  (done_timeout),
    .pending       (pending),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm with a mask; on return the block is one cycle past the arm.
  task automatic do_arm(input logic [NP-1:0] m);
    arm = 1'b1; expect_mask = m;
    tick();
    arm = 1'b0; expect_mask = '0;
  endtask

  // Consume the record; on return the block should be idle.
  task automatic do_handshake(input string tag);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    tests++;
    if (busy !== 1'b0 || done_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: busy=%b done_valid=%b, required 0 0", tag, busy, done_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++;
    if ({resp_ready, done_valid, done_err, done_err_mask, done_timeout, pending, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rr=%b dv=%b de=%b dem=%b dt=%b pend=%b busy=%b, required all 0",
               resp_ready, done_valid, done_err, done_err_mask, done_timeout, pending, busy);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_same_cycle();
    do_arm(4'b1011);
    tests++;
    if (resp_ready !== 4'b1011 || pending !== 4'b1011 || busy !== 1'b1) begin
      fails++;
      $display("FAIL same_armed: rr=%b pend=%b busy=%b, required 1011 1011 1", resp_ready, pending, busy);
    end
    resp_valid = 4'b1011; resp_err = 4'b0000;
    tick();
    resp_valid = '0;
    tests++;
    if (done_valid !== 1'b1 || done_err_mask !== 4'b0000 || done_err !== 1'b0 ||
        pending !== 4'b0000 || resp_ready !== 4'b0000) begin
      fails++;
      $display("FAIL same_done: dv=%b dem=%b de=%b pend=%b rr=%b, required 1 0000 0 0000 0000",
               done_valid, done_err_mask, done_err, pending, resp_ready);
    end
    do_handshake("same");
  endtask

  task automatic test_staggered();
    do_arm(4'b0110);                         // now at +1
    resp_valid = 4'b0001;                    // port 0 never expected
    tests++;
    if (resp_ready !== 4'b0110) begin
      fails++;
      $display("FAIL stag_ready: rr=%b, required 0110", resp_ready);
    end
    tick(); tick();                          // now at +3
    resp_valid = 4'b0101; resp_err = 4'b0100;
    tick();                                  // now at +4
    resp_valid = 4'b0001; resp_err = 4'b0000;
    tests++;
    if (pending !== 4'b0010 || done_err_mask !== 4'b0100 || done_valid !== 1'b0) begin
      fails++;
      $display("FAIL stag_mid: pend=%b dem=%b dv=%b, required 0010 0100 0", pending, done_err_mask, done_valid);
    end
    tick(); tick(); tick();                  // now at +7
    tests++;
    if (done_valid !== 1'b0 || resp_ready !== 4'b0010) begin
      fails++;
      $display("FAIL stag_before: dv=%b rr=%b, required 0 0010", done_valid, resp_ready);
    end
    resp_valid = 4'b0011;
    tick();                                  // now at +8
    resp_valid = '0;
    tests++;
    if (done_valid !== 1'b1 || done_err_mask !== 4'b0100 || done_err !== 1'b1 || pending !== 4'b0000) begin
      fails++;
      $display("FAIL stag_done: dv=%b dem=%b de=%b pend=%b, required 1 0100 1 0000",
               done_valid, done_err_mask, done_err, pending);
    end
    do_handshake("stag");
  endtask

  task automatic test_empty_mask();
    do_arm(4'b0000);
    tests++;
    if (done_valid !== 1'b1 || done_err !== 1'b0) begin
      fails++;
      $display("FAIL empty_done: dv=%b de=%b, required 1 0", done_valid, done_err);
    end
    arm = 1'b1; expect_mask = 4'b1111;       // must be ignored in DONE
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (done_valid !== 1'b1 || pending !== 4'b0000 || done_err_mask !== 4'b0000 ||
          done_err !== 1'b0 || resp_ready !== 4'b0000) begin
        fails++;
        $display("FAIL empty_hold%0d: dv=%b pend=%b dem=%b de=%b rr=%b, required 1 0000 0000 0 0000",
                 i, done_valid, pending, done_err_mask, done_err, resp_ready);
      end
    end
    arm = 1'b0; expect_mask = '0;
    do_handshake("empty");
  endtask

`ifdef TSWITCH_COLLECTOR_TIMEOUT_EN
  task automatic test_timeout();
    do_arm(4'b0011);                         // +1
    resp_valid = 4'b0001;
    tick();                                  // +2
    resp_valid = '0;
    for (int k = 2; k <= 8; k++) begin
      tests++;
      if (done_valid !== 1'b0) begin
        fails++;
        $display("FAIL tmo_early%0d: dv=%b, required 0", k, done_valid);
      end
      tick();
    end                                      // +9
    tests++;
    if (done_valid !== 1'b1 || done_timeout !== 1'b1 || done_err !== 1'b1 ||
        pending !== 4'b0010 || done_err_mask !== 4'b0000) begin
      fails++;
      $display("FAIL tmo_done: dv=%b dt=%b de=%b pend=%b dem=%b, required 1 1 1 0010 0000",
               done_valid, done_timeout, done_err, pending, done_err_mask);
    end
    do_handshake("tmo");
  endtask

  task automatic test_timeout_boundary();
    do_arm(4'b0001);                         // +1, timer 0
    for (int k = 1; k < 8; k++) tick();      // +8, timer at limit
    resp_valid = 4'b0001;
    tick();
    resp_valid = '0;
    tests++;
    if (done_valid !== 1'b1 || done_timeout !== 1'b0 || done_err !== 1'b0 || pending !== 4'b0000) begin
      fails++;
      $display("FAIL tmo_edge: dv=%b dt=%b de=%b pend=%b, required 1 0 0 0000",
               done_valid, done_timeout, done_err, pending);
    end
    do_handshake("tmo_edge");
  endtask
`else
  task automatic test_no_timeout();
    do_arm(4'b0001);
    for (int k = 0; k < 30; k++) tick();
    tests++;
    if (done_valid !== 1'b0 || busy !== 1'b1 || resp_ready !== 4'b0001 || done_timeout !== 1'b0) begin
      fails++;
      $display("FAIL notmo_wait: dv=%b busy=%b rr=%b dt=%b, required 0 1 0001 0",
               done_valid, busy, resp_ready, done_timeout);
    end
    resp_valid = 4'b0001;
    tick();
    resp_valid = '0;
    tests++;
    if (done_valid !== 1'b1 || done_timeout !== 1'b0) begin
      fails++;
      $display("FAIL notmo_done: dv=%b dt=%b, required 1 0", done_valid, done_timeout);
    end
    do_handshake("notmo");
  endtask
`endif

  task automatic test_abort();
    do_arm(4'b1100);
    resp_valid = 4'b0100; resp_err = 4'b0100; abort = 1'b1;
    #1;
    tests++;
    if (resp_ready !== 4'b0000) begin
      fails++;
      $display("FAIL abort_ready: rr=%b, required 0000", resp_ready);
    end
    tick();
    abort = 1'b0; resp_valid = '0; resp_err = '0;
    tests++;
    if (busy !== 1'b0 || pending !== 4'b0000 || done_err_mask !== 4'b0000 || done_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b pend=%b dem=%b dv=%b, required 0 0000 0000 0",
               busy, pending, done_err_mask, done_valid);
    end
    do_arm(4'b0001);
    tests++;
    if (busy !== 1'b1 || resp_ready !== 4'b0001) begin
      fails++;
      $display("FAIL abort_rearm: busy=%b rr=%b, required 1 0001", busy, resp_ready);
    end
    resp_valid = 4'b0001;
    tick();
    resp_valid = '0;
    do_handshake("abort");
  endtask

  task automatic test_async_reset();
    do_arm(4'b0011);
    resp_valid = 4'b0001; resp_err = 4'b0001;
    tick();
    resp_valid = '0; resp_err = '0;
    tests++;
    if (pending !== 4'b0010 || done_err_mask !== 4'b0001) begin
      fails++;
      $display("FAIL arst_pre: pend=%b dem=%b, required 0010 0001", pending, done_err_mask);
    end
    #2 rst_n = 1'b0;                         // mid-cycle, away from any edge
    #1;
    tests++;
    if ({resp_ready, done_valid, done_err, done_err_mask, done_timeout, pending, busy} !== '0) begin
      fails++;
      $display("FAIL arst_outputs: rr=%b dv=%b de=%b dem=%b dt=%b pend=%b busy=%b, required all 0",
               resp_ready, done_valid, done_err, done_err_mask, done_timeout, pending, busy);
    end
    #1 rst_n = 1'b1;
    tick();
    do_arm(4'b1000);
    tests++;
    if (busy !== 1'b1 || resp_ready !== 4'b1000) begin
      fails++;
      $display("FAIL arst_rearm: busy=%b rr=%b, required 1 1000", busy, resp_ready);
    end
    resp_valid = 4'b1000;
    tick();
    resp_valid = '0;
    tests++;
    if (done_valid !== 1'b1 || done_err !== 1'b0) begin
      fails++;
      $display("FAIL arst_done: dv=%b de=%b, required 1 0", done_valid, done_err);
    end
    do_handshake("arst");
  endtask

  initial begin
    arm = 1'b0; expect_mask = '0; abort = 1'b0;
    resp_valid = '0; resp_err = '0; done_ready = 1'b0;
    test_reset();
    test_same_cycle();
    test_staggered();
    test_empty_mask();
`ifdef TSWITCH_COLLECTOR_TIMEOUT_EN
    test_timeout();
    test_timeout_boundary();
`else
    test_no_timeout();
`endif
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a stimulus path stalls unexpectedly.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/response_collector.md
# response_collector

Downstream companion to the parallel issue stage in the switch datapath. Once requests go out to several ports in parallel, this block gathers one response per targeted port, tracks which ports are still outstanding and merges their error flags. It presents a single completion record to the controlling engine (read requester / multicast engine), with optional timeout protection against a port that never answers.

## Interface
- NUM_PORTS, 4, number of egress/target ports
- TIMEOUT_CYCLES, 1024, WAIT cycles before a timeout completion (≥2); counter width $clog2(TIMEOUT_CYCLES)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- arm  input  1  pulse: start collecting for expect_mask; honoured only in IDLE
- expect_mask  input  NUM_PORTS  ports expected to respond; sampled on accepted arm
- abort  input  1  return to IDLE from any state, discarding all state
- resp_valid  input  NUM_PORTS  per-port response valid
- resp_err  input  NUM_PORTS  per-port error flag, qualified by resp_valid
- resp_ready  output  NUM_PORTS  per-port accept
- done_valid  output  1  completion record valid
- done_ready  input  1  consumer accepts completion
- done_err  output  1  OR of done_err_mask, or timeout
- done_err_mask  output  NUM_PORTS  ports that returned resp_err=1
- done_timeout  output  1  completion caused by timeout
- pending  output  NUM_PORTS  ports still outstanding
- busy  output  1  state != IDLE

## Operation
- States: IDLE, WAIT, DONE.
- Reset: state IDLE. Outputs resp_ready, done_valid, done_err, done_err_mask, done_timeout, pending and busy are all 0. Timer is 0.
- IDLE, arm=1:
  - pending <= expect_mask, err_mask <= 0, timer <= 0, timeout flag <= 0.
  - Next state is WAIT, or DONE directly if expect_mask==0.
- arm outside IDLE is ignored; no queueing.
- WAIT:
  - resp_ready[i] = pending[i].
  - Accept on port i when resp_valid[i] && resp_ready[i]: clear pending[i]; err_mask[i] <= resp_err[i].
  - Any subset of ports may be accepted in the same cycle.
  - resp_valid on a non-pending port is never accepted (ready stays 0).
  - If (pending & ~accepted)==0, go to DONE.
- DONE:
  - done_valid=1. done_err_mask, done_timeout, done_err and pending are held stable.
  - done_valid && done_ready returns to IDLE.
  - resp_ready=0.
- IDLE also drives resp_ready=0.
- abort has highest priority in every state. Next cycle: IDLE, pending=0, err_mask=0, timer=0. A same-cycle response is not accepted: resp_ready is forced to 0 while abort=1.

## Timing
- arm at cycle N: resp_ready visible at N+1.
- Last pending response accepted at cycle N: done_valid at N+1.
- expect_mask==0: done_valid at N+1 after arm.
- Throughput: minimum one IDLE cycle between done handshake and next accepted arm, giving an arm-to-arm minimum of 3 cycles.
- Timer (TIMEOUT_EN only):
  - Increments every WAIT cycle, saturates at TIMEOUT_CYCLES-1.
  - WAIT cycle with timer==TIMEOUT_CYCLES-1 and ports still pending after this cycle's accepts: go to DONE with done_timeout=1 and done_err=1. pending shows the missing ports.
  - A cycle that completes the last pending bit and hits the timeout limit completes normally, with done_timeout=0.
- done_err = |done_err_mask | done_timeout.

## Configuration
- TSWITCH_COLLECTOR_TIMEOUT_EN defined: timer and timeout path present as above.
- Not defined:
  - No timer logic.
  - done_timeout tied 0.
  - WAIT persists until all pending responses arrive or abort.
  - TIMEOUT_CYCLES unused.

## Test plan
- NUM_PORTS=4, arm with expect_mask=4'b1011; resp_valid on ports 0,1,3 in one cycle, resp_err=0 -> all accepted same cycle; done_valid next cycle with done_err_mask=0 and done_err=0.
- expect_mask=4'b0110; port 2 responds at cycle +3 with err=1, port 1 at +7 with err=0; resp_valid on port 0 held throughout -> port 0 never ready; done_err_mask=4'b0100, done_err=1; done_valid one cycle after the port-1 accept.
- expect_mask=4'b0000 -> done_valid 1 cycle after arm, done_err=0; done_ready held low 5 cycles -> record stable, arm during DONE ignored.
- TIMEOUT_EN, TIMEOUT_CYCLES=8, expect_mask=4'b0011, only port 0 responds -> done_valid 9 cycles after arm, with done_timeout=1, done_err=1 and pending=4'b0010.
- abort in WAIT with pending=4'b1100 while resp_valid[2]=1 -> no accept that cycle; next cycle busy=0, pending=0; a new arm is then accepted.
- rst_n asserted mid-WAIT -> all outputs 0 immediately (asynchronously); after release the block is in IDLE and accepts arm.
